// File: rtl/multicycle_adder.sv
// Multi-cycle adder/subtractor. It adds CHUNK bits per cycle, starting with the LSB slice,
// and uses valid/ready handshakes on both the input side and the output side.
module mca_chunk_add #(
  parameter int CW = 8
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] s,
  output logic          cout
);
  logic [CW:0] sum;
  assign sum  = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
  assign s    = sum[CW-1:0];
  assign cout = sum[CW];
endmodule

module multicycle_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Pin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Pout,
  output logic             Ovf
);
  localparam int CH = (CHUNK < 1) ? 1 : CHUNK;
  localparam int N  = WIDTH / CH;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] KLAST = KW'(N - 1);

  generate
    if (CHUNK < 1 || WIDTH < 1 || (WIDTH % CH) != 0) begin : g_bad_cfg
      $error("multicycle_adder: WIDTH must be a positive multiple of CHUNK (CHUNK >= 1)");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;

  logic [N-1:0][CH-1:0] ar_q, ar_d, br_q, br_d, res_q, res_d;
  logic [WIDTH-1:0]     s_q, s_d;
  logic [KW-1:0]        k_q, k_d;
  logic                 carry_q, carry_d, pout_q, pout_d, ovf_q, ovf_d;
  logic [CH-1:0]        slice_s;
  logic                 slice_c;

  mca_chunk_add #(.CW(CH)) u_add (
    .a    (ar_q[k_q]),
    .b    (br_q[k_q]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)       state_d = CALC;
      CALC:    if (k_q == KLAST)   state_d = DONE;
      DONE:    if (out_ready)      state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // The visible result registers update only on the last slice. This keeps S, Pout, and Ovf stable through IDLE and CALC.
  always_comb begin
    ar_d    = ar_q;
    br_d    = br_q;
    res_d   = res_q;
    carry_d = carry_q;
    k_d     = k_q;
    s_d     = s_q;
    pout_d  = pout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (in_valid) begin
        ar_d    = A;
        br_d    = sub ? ~B : B;
        carry_d = sub ^ Pin;
        k_d     = '0;
      end
      CALC: begin
        res_d[k_q] = slice_s;
        carry_d    = slice_c;
        k_d        = k_q + 1'b1;
        if (k_q == KLAST) begin
          k_d    = '0;
          s_d    = res_d;
          pout_d = slice_c;
          ovf_d  = (ar_q[N-1][CH-1] == br_q[N-1][CH-1]) &&
                   (res_d[N-1][CH-1] != ar_q[N-1][CH-1]);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_q    <= '0;
      br_q    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      s_q     <= '0;
      pout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      ar_q    <= ar_d;
      br_q    <= br_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      s_q     <= s_d;
      pout_q  <= pout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign S    = s_q;
  assign Pout = pout_q;
  assign Ovf  = ovf_q;
endmodule

// File: tb/tb_multicycle_adder.sv
// Directed bench for multicycle_adder. It covers the default CHUNK=8 build and a single-cycle build with CHUNK=32.
module tb_multicycle_adder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0, Pin = 1'b0, sub = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic        in_ready, out_valid, Pout, Ovf;
  logic [31:0] S;

  logic        in_valid1 = 1'b0, out_ready1 = 1'b0, Pin1 = 1'b0, sub1 = 1'b0;
  logic [31:0] A1 = '0, B1 = '0;
  logic        in_ready1, out_valid1, Pout1, Ovf1;
  logic [31:0] S1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Pin(Pin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .S(S), .Pout(Pout), .Ovf(Ovf));

  multicycle_adder #(.WIDTH(32), .CHUNK(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .A(A1), .B(B1), .Pin(Pin1), .sub(sub1), .out_valid(out_valid1),
    .out_ready(out_ready1), .S(S1), .Pout(Pout1), .Ovf(Ovf1));

  // Drives one operand at posedge+1. It returns the number of cycles from the accept edge until out_valid, or -1 on timeout.
  // busy_bad is set if in_ready is seen high at any point while the operation is in flight.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic pin,
                        input logic sb, output int lat, output logic busy_bad);
    A = a; B = b; Pin = pin; sub = sb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    busy_bad = in_ready;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (in_ready) busy_bad = 1'b1;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if ({S, Pout, Ovf} !== 34'h0) begin errors++; $display("FAIL reset_outputs got S=%h P=%b O=%b want 0", S, Pout, Ovf); end
    checks++; if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || S1 !== 32'h0) begin
      errors++; $display("FAIL reset_single got rdy=%b vld=%b S=%h want 1 0 0", in_ready1, out_valid1, S1); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_add();
    int lat; logic bb;
    out_ready = 1'b1;
    run_op(32'd100, 32'd300, 1'b0, 1'b0, lat, bb);
    checks++; if (lat !== 4) begin errors++; $display("FAIL add_latency got %0d want 4", lat); end
    checks++; if (bb !== 1'b0) begin errors++; $display("FAIL add_busy_in_ready got high want low"); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL add_done_in_ready got %b want 0", in_ready); end
    checks++; if (S !== 32'd400 || Pout !== 1'b0 || Ovf !== 1'b0) begin
      errors++; $display("FAIL add_result got S=%0d P=%b O=%b want 400 0 0", S, Pout, Ovf); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL add_consume got vld=%b rdy=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_overflow();
    int lat; logic bb;
    run_op(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0, lat, bb);
    checks++; if (lat !== 4 || S !== 32'hFFFFFFFF || Pout !== 1'b0 || Ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_pos got lat=%0d S=%h P=%b O=%b want 4 ffffffff 0 1", lat, S, Pout, Ovf); end
    @(posedge clk); #1;
    run_op(32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, lat, bb);
    checks++; if (lat !== 4 || S !== 32'h0 || Pout !== 1'b1 || Ovf !== 1'b0) begin
      errors++; $display("FAIL wrap got lat=%0d S=%h P=%b O=%b want 4 0 1 0", lat, S, Pout, Ovf); end
    @(posedge clk); #1;
  endtask

  task automatic test_subtract();
    int lat; logic bb;
    run_op(32'd1337, 32'd228, 1'b0, 1'b1, lat, bb);
    checks++; if (lat !== 4 || S !== 32'd1109 || Pout !== 1'b1 || Ovf !== 1'b0) begin
      errors++; $display("FAIL sub_basic got lat=%0d S=%0d P=%b O=%b want 4 1109 1 0", lat, S, Pout, Ovf); end
    @(posedge clk); #1;
    run_op(32'd0, 32'd1, 1'b0, 1'b1, lat, bb);
    checks++; if (S !== 32'hFFFFFFFF || Pout !== 1'b0 || Ovf !== 1'b0) begin
      errors++; $display("FAIL sub_borrow got S=%h P=%b O=%b want ffffffff 0 0", S, Pout, Ovf); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat; logic bb;
    out_ready = 1'b0;
    run_op(32'd228, 32'd1488, 1'b1, 1'b0, lat, bb);
    A = 32'd5; B = 32'd5; Pin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || S !== 32'd1717 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d] got vld=%b S=%0d rdy=%b want 1 1717 0", i, out_valid, S, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got vld=%b rdy=%b want 0 1", out_valid, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 4 || out_valid !== 1'b1 || S !== 32'd10) begin
      errors++; $display("FAIL bp_next got lat=%0d vld=%b S=%0d want 4 1 10", lat, out_valid, S); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int cyc, first, second;
    first = -1; second = -1;
    A = 32'd3; B = 32'd4; Pin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (cyc = 0; cyc < 40 && second < 0; cyc++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        if (first < 0) first = cyc; else second = cyc;
      end
    end
    in_valid = 1'b0;
    checks++; if (first < 0 || second - first !== 6) begin
      errors++; $display("FAIL b2b_period got %0d want 6", second - first); end
    checks++; if (S !== 32'd7) begin errors++; $display("FAIL b2b_result got %0d want 7", S); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op();
    int lat; logic bb;
    A = 32'd1; B = 32'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || S !== 32'h0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid got vld=%b S=%h rdy=%b want 0 0 1", out_valid, S, in_ready); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) begin checks++; errors++; $display("FAIL rst_stray got vld=1 want 0"); end
    end
    run_op(32'd500000, 32'd10, 1'b0, 1'b0, lat, bb);
    checks++; if (lat !== 4 || S !== 32'd500010) begin
      errors++; $display("FAIL rst_next got lat=%0d S=%0d want 4 500010", lat, S); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_cycle();
    A1 = 32'd100; B1 = 32'd300; Pin1 = 1'b0; sub1 = 1'b0; out_ready1 = 1'b1; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    checks++; if (in_ready1 !== 1'b0 || out_valid1 !== 1'b0) begin
      errors++; $display("FAIL sc_calc got rdy=%b vld=%b want 0 0", in_ready1, out_valid1); end
    @(posedge clk); #1;
    checks++; if (out_valid1 !== 1'b1 || S1 !== 32'd400 || Pout1 !== 1'b0 || Ovf1 !== 1'b0) begin
      errors++; $display("FAIL sc_result got vld=%b S=%0d P=%b O=%b want 1 400 0 0", out_valid1, S1, Pout1, Ovf1); end
    @(posedge clk); #1;
    checks++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
      errors++; $display("FAIL sc_consume got vld=%b rdy=%b want 0 1", out_valid1, in_ready1); end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic_add();
    test_overflow();
    test_subtract();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    test_single_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_adder.md
Name: multicycle_adder

Overview:
- Parametrised successor to the single-cycle 32-bit full adder.
- Adds (or subtracts) two WIDTH-bit operands with carry-in over WIDTH/CHUNK clock cycles, CHUNK bits per cycle, LSB slice first.
- Uses valid/ready handshakes on input and output, so it sits between operand producers and result consumers without extra glue.
- Trades latency for a short carry chain (one CHUNK-bit adder).

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits added per cycle; CHUNK = WIDTH gives single-cycle operation.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and mode valid.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Pin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0 = A+B+Pin, 1 = A-B-Pin.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- S  output  WIDTH  sum/difference.
- Pout  output  1  carry-out (raw carry of the internal add).
- Ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; in_ready=1; out_valid=0; S=0; Pout=0; Ovf=0; all internal registers 0.
- Reset asserted mid-operation aborts it; no result is produced.
- Defines N = WIDTH/CHUNK. Elaboration must fail if WIDTH % CHUNK != 0 or CHUNK < 1.

FSM:
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready, latch the following and go to CALC with slice counter k=0:
    - Ar=A.
    - Br = sub ? ~B : B.
    - carry = sub ? ~Pin : Pin.
- CALC:
  - in_ready=0.
  - Each cycle, compute {c, s} = Ar[k*CHUNK +: CHUNK] + Br[k*CHUNK +: CHUNK] + carry.
  - Write s into result slice k, set carry=c, k=k+1.
  - On the cycle processing k=N-1, the next state is DONE.
  - Exactly N cycles are spent in CALC.
- DONE:
  - out_valid=1.
  - S holds the full result, Pout=final carry, Ovf = (Ar[WIDTH-1]==Br[WIDTH-1]) && (S[WIDTH-1]!=Ar[WIDTH-1]).
  - Outputs remain stable while out_ready=0.
  - On out_valid && out_ready, go to IDLE.

Timing and handshake rules:
- Latency: out_valid rises N cycles after the accepting edge (N=4 at defaults). The operand is accepted at edge 0, and out_valid=1 after edge N.
- Throughput: one operation per N+2 cycles when out_ready is held high. No overlap between operations.
- in_ready is 0 in CALC and DONE. in_valid in those states is ignored, and A/B/Pin/sub may change freely after acceptance.
- S/Pout/Ovf keep their last value in IDLE until the next DONE; they are only meaningful while out_valid=1.
- Wrap-around: the sum is taken modulo 2^WIDTH, and the carry beyond bit WIDTH-1 goes to Pout only.
- Subtract: Pout=1 means no borrow.
- Simultaneous out_ready and in_valid in DONE: the result is consumed, but the new operand is not accepted that cycle (in_ready=0); it is accepted in the next IDLE cycle.
- in_valid held high in IDLE after reset: accepted on the first rising edge after rst_n deasserts.

Test Plan (WIDTH=32, CHUNK=8 unless noted):
1. A=100, B=300, Pin=0, sub=0, out_ready=1.
   - S=400, Pout=0, Ovf=0.
   - out_valid rises exactly 4 cycles after accept; in_ready=0 for those cycles plus the DONE cycle.
2. A=0x7FFFFFFF, B=0x7FFFFFFF, Pin=1 → S=0xFFFFFFFF, Pout=0, Ovf=1.
3. A=0x80000000, B=0x7FFFFFFF, Pin=1 → S=0x00000000, Pout=1, Ovf=0.
4. Subtract cases:
   - sub=1, A=1337, B=228, Pin=0 → S=1109, Pout=1, Ovf=0.
   - sub=1, A=0, B=1, Pin=0 → S=0xFFFFFFFF, Pout=0, Ovf=0.
5. Backpressure and ignored input:
   - Stimulus: A=228, B=1488, Pin=1; hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with A=5, B=5.
   - Required: S=1717 stays stable and out_valid stays 1. Then out_ready=1 gives one handshake, and the next accepted operation yields S=10.
6. Reset mid-operation, then single-cycle configuration:
   - Pulse rst_n=0 during CALC cycle 2 → out_valid=0, S=0, in_ready=1 immediately (asynchronous). The next operation 500000+10 gives S=500010.
   - Repeat case 1 with CHUNK=32 → out_valid 1 cycle after accept, S=400.
